// File: rtl/regfile_port_arbiter_if.sv
// Request/response and register-file port bundle for regfile_port_arbiter.
// The slave modport is the arbiter side; the master modport is the clients plus the file.
interface regfile_port_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 4,
  parameter int NUM_CLIENTS   = 2
);
  localparam int ADDR_WIDTH = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;

  logic [NUM_CLIENTS-1:0]            req_valid_i;
  logic [NUM_CLIENTS-1:0]            req_ready_o;
  logic [NUM_CLIENTS-1:0]            req_write_i;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_CLIENTS-1:0]            resp_valid_o;
  logic [DATA_WIDTH-1:0]             resp_data_o;
  logic                              resp_error_o;
  logic [NUM_REGISTERS-1:0]          rf_register_select_o;
  logic                              rf_write_select_o;
  logic [DATA_WIDTH-1:0]             rf_data_o;
  logic [DATA_WIDTH-1:0]             rf_data_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_data_i, rf_data_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_error_o,
           rf_register_select_o, rf_write_select_o, rf_data_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_data_i, rf_data_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_error_o,
           rf_register_select_o, rf_write_select_o, rf_data_o
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter feeding one register-file port; responses return two cycles after accept.
// Define REGFILE_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority instead.
module regfile_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 4,
  parameter int NUM_CLIENTS   = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  regfile_port_arbiter_if.slave bus
);
  localparam int ADDR_WIDTH = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
  localparam int ID_WIDTH   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [ADDR_WIDTH-1:0]    client_addr [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0]    client_data [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0]   grant;
  logic [ID_WIDTH-1:0]      grant_id;
  logic                     accept;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [NUM_REGISTERS-1:0] select_next;

  logic                     issue_valid_reg;
  logic [ID_WIDTH-1:0]      issue_id_reg;
  logic                     issue_write_reg;
  logic                     issue_err_reg;
  logic [NUM_REGISTERS-1:0] select_reg;
  logic [DATA_WIDTH-1:0]    rf_data_reg;

  logic [NUM_CLIENTS-1:0]   resp_valid_reg;
  logic [DATA_WIDTH-1:0]    resp_data_reg;
  logic                     resp_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign client_addr[gi] = bus.req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign client_data[gi] = bus.req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
  always_comb begin
    logic found;
    found    = 1'b0;
    grant_id = '0;
    grant    = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!found && bus.req_valid_i[i]) begin
        found    = 1'b1;
        grant_id = ID_WIDTH'(i);
      end
    end
    accept = found & ~reset_i;
    if (accept) grant[grant_id] = 1'b1;
  end
`else
  logic [ID_WIDTH-1:0] rr_ptr_reg;
  logic [ID_WIDTH-1:0] rr_ptr_next;

  // Search from rr_ptr upward, wrapping, so the last winner goes to the back of the line.
  always_comb begin
    logic found;
    int   idx;
    found    = 1'b0;
    idx      = 0;
    grant_id = '0;
    grant    = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!found && bus.req_valid_i[idx]) begin
        found    = 1'b1;
        grant_id = ID_WIDTH'(idx);
      end
    end
    accept = found & ~reset_i;
    if (accept) grant[grant_id] = 1'b1;
    rr_ptr_next = rr_ptr_reg;
    if (accept) begin
      rr_ptr_next = (int'(grant_id) == NUM_CLIENTS - 1) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rr_ptr_reg <= '0;
    else         rr_ptr_reg <= rr_ptr_next;
  end
`endif

  assign sel_addr = client_addr[grant_id];

  // Out-of-range addresses match no bit, so the select is naturally all-zero for them.
  generate
    for (gi = 0; gi < NUM_REGISTERS; gi++) begin : g_decode
      assign select_next[gi] = accept && (sel_addr == ADDR_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      issue_valid_reg <= 1'b0;
      issue_id_reg    <= '0;
      issue_write_reg <= 1'b0;
      issue_err_reg   <= 1'b0;
      select_reg      <= '0;
      rf_data_reg     <= '0;
    end else begin
      issue_valid_reg <= accept;
      select_reg      <= select_next;
      if (accept) begin
        issue_id_reg    <= grant_id;
        issue_write_reg <= bus.req_write_i[grant_id];
        issue_err_reg   <= (int'(sel_addr) >= NUM_REGISTERS);
        rf_data_reg     <= client_data[grant_id];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_valid_reg <= '0;
      resp_data_reg  <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= issue_valid_reg ? (NUM_CLIENTS'(1) << issue_id_reg) : '0;
      if (issue_valid_reg) begin
        resp_err_reg  <= issue_err_reg;
        resp_data_reg <= issue_err_reg   ? '0 :
                         issue_write_reg ? rf_data_reg : bus.rf_data_i;
      end
    end
  end

  assign bus.req_ready_o          = grant;
  assign bus.rf_register_select_o = select_reg;
  // Gated by reset so a write already in the issue stage never reaches the file.
  assign bus.rf_write_select_o    = issue_valid_reg & issue_write_reg & ~issue_err_reg & ~reset_i;
  assign bus.rf_data_o            = rf_data_reg;
  assign bus.resp_valid_o         = resp_valid_reg;
  assign bus.resp_data_o          = resp_data_reg;
  assign bus.resp_error_o         = resp_err_reg;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter: a 4-register instance with a file model,
// plus a 3-register instance for out-of-range handling.
module tb_regfile_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  regfile_port_arbiter_if #(.DATA_WIDTH(32), .NUM_REGISTERS(4), .NUM_CLIENTS(2)) bus_a ();
  regfile_port_arbiter_if #(.DATA_WIDTH(32), .NUM_REGISTERS(3), .NUM_CLIENTS(2)) bus_b ();

  regfile_port_arbiter #(.DATA_WIDTH(32), .NUM_REGISTERS(4), .NUM_CLIENTS(2)) dut_a (
    .clk_i(clk), .reset_i(rst), .bus(bus_a.slave));
  regfile_port_arbiter #(.DATA_WIDTH(32), .NUM_REGISTERS(3), .NUM_CLIENTS(2)) dut_b (
    .clk_i(clk), .reset_i(rst), .bus(bus_b.slave));

  typedef struct packed {
    logic [7:0]  client;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t q_a[$];
  resp_t q_b[$];
  resp_t ea, eb;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  // Register-file model attached to instance A
  logic [31:0] mem_a [4];
  logic        load_en = 1'b0;
  int          load_idx = 0;
  logic [31:0] load_val = '0;
  bit          b_write_seen = 1'b0;

  always_comb begin
    bus_a.rf_data_i = '0;
    for (int r = 0; r < 4; r++)
      if (bus_a.rf_register_select_o[r]) bus_a.rf_data_i = mem_a[r];
  end

  always @(posedge clk) begin
    if (load_en) mem_a[load_idx] <= load_val;
    else if (bus_a.rf_write_select_o)
      for (int r = 0; r < 4; r++)
        if (bus_a.rf_register_select_o[r]) mem_a[r] <= bus_a.rf_data_o;
  end

  assign bus_b.rf_data_i = (|bus_b.rf_register_select_o) ? 32'hC0DE0000 : 32'h0;
  always @(posedge clk) if (bus_b.rf_write_select_o) b_write_seen <= 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && bus_a.resp_valid_o !== 2'b00) begin
      $display("resp A: valid %b data %h err %b", bus_a.resp_valid_o, bus_a.resp_data_o, bus_a.resp_error_o);
      if (q_a.size() == 0) begin
        check("resp_a_unexpected", 64'(bus_a.resp_valid_o), 64'd0);
      end else begin
        ea = q_a.pop_front();
        check("resp_a_valid", 64'(bus_a.resp_valid_o), 64'd1 << ea.client);
        check("resp_a_data", 64'(bus_a.resp_data_o), 64'(ea.data));
        check("resp_a_error", 64'(bus_a.resp_error_o), 64'(ea.err));
      end
    end
    if (mon_en && bus_b.resp_valid_o !== 2'b00) begin
      $display("resp B: valid %b data %h err %b", bus_b.resp_valid_o, bus_b.resp_data_o, bus_b.resp_error_o);
      if (q_b.size() == 0) begin
        check("resp_b_unexpected", 64'(bus_b.resp_valid_o), 64'd0);
      end else begin
        eb = q_b.pop_front();
        check("resp_b_valid", 64'(bus_b.resp_valid_o), 64'd1 << eb.client);
        check("resp_b_data", 64'(bus_b.resp_data_o), 64'(eb.data));
        check("resp_b_error", 64'(bus_b.resp_error_o), 64'(eb.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus_a.req_valid_i = '0; bus_a.req_write_i = '0; bus_a.req_addr_i = '0; bus_a.req_data_i = '0;
    bus_b.req_valid_i = '0; bus_b.req_write_i = '0; bus_b.req_addr_i = '0; bus_b.req_data_i = '0;
  endtask

  task automatic drive_a(input int c, input bit w, input int a, input logic [31:0] d);
    bus_a.req_valid_i[c]          = 1'b1;
    bus_a.req_write_i[c]          = w;
    bus_a.req_addr_i[c*2 +: 2]    = a[1:0];
    bus_a.req_data_i[c*32 +: 32]  = d;
    $display("req A: client %0d write %0b addr %0d data %h", c, w, a, d);
  endtask

  task automatic drive_b(input int c, input bit w, input int a, input logic [31:0] d);
    bus_b.req_valid_i[c]          = 1'b1;
    bus_b.req_write_i[c]          = w;
    bus_b.req_addr_i[c*2 +: 2]    = a[1:0];
    bus_b.req_data_i[c*32 +: 32]  = d;
    $display("req B: client %0d write %0b addr %0d data %h", c, w, a, d);
  endtask

  task automatic load(input int idx, input logic [31:0] val);
    load_en = 1'b1; load_idx = idx; load_val = val;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_c;
    rst = 1'b1;
    clear_reqs();
    bus_a.req_valid_i = 2'b11;
    repeat (2) tick();
    @(negedge clk);
    check("reset_ready", 64'(bus_a.req_ready_o), 64'd0);
    check("reset_resp_valid", 64'(bus_a.resp_valid_o), 64'd0);
    check("reset_resp_data", 64'(bus_a.resp_data_o), 64'd0);
    check("reset_resp_error", 64'(bus_a.resp_error_o), 64'd0);
    check("reset_select", 64'(bus_a.rf_register_select_o), 64'd0);
    check("reset_write_sel", 64'(bus_a.rf_write_select_o), 64'd0);
    check("reset_rf_data", 64'(bus_a.rf_data_o), 64'd0);
    tick();
    clear_reqs();
    rst = 1'b0;
    mon_en = 1'b1;
    load(1, 32'h11111111);
    load(2, 32'hDEADBEEF);
    load(3, 32'h00000000);

    // Single read of reg 2 by client 0
    drive_a(0, 1'b0, 2, 32'h0);
    @(negedge clk);
    check("read_ready", 64'(bus_a.req_ready_o), 64'b01);
    q_a.push_back('{client: 8'd0, data: 32'hDEADBEEF, err: 1'b0});
    tick();
    clear_reqs();
    @(negedge clk);
    check("read_select", 64'(bus_a.rf_register_select_o), 64'b0100);
    check("read_write_sel", 64'(bus_a.rf_write_select_o), 64'd0);
    repeat (3) tick();

    // Write reg 3 then read it back the next cycle
    drive_a(1, 1'b1, 3, 32'h12345678);
    @(negedge clk);
    check("wr_ready", 64'(bus_a.req_ready_o), 64'b10);
    q_a.push_back('{client: 8'd1, data: 32'h12345678, err: 1'b0});
    tick();
    clear_reqs();
    drive_a(1, 1'b0, 3, 32'h0);
    @(negedge clk);
    check("wr_write_sel", 64'(bus_a.rf_write_select_o), 64'd1);
    check("wr_select", 64'(bus_a.rf_register_select_o), 64'b1000);
    check("wr_rf_data", 64'(bus_a.rf_data_o), 64'h12345678);
    check("raw_ready", 64'(bus_a.req_ready_o), 64'b10);
    q_a.push_back('{client: 8'd1, data: 32'h12345678, err: 1'b0});
    tick();
    clear_reqs();
    @(negedge clk);
    check("raw_write_sel", 64'(bus_a.rf_write_select_o), 64'd0);
    check("raw_select", 64'(bus_a.rf_register_select_o), 64'b1000);
    repeat (4) tick();

    // Both clients hold valid for six cycles
    for (int k = 0; k < 6; k++) begin
      clear_reqs();
      drive_a(0, 1'b0, 2, 32'h0);
      drive_a(1, 1'b0, 3, 32'h0);
      exp_c = FIXED ? 0 : (k % 2);
      @(negedge clk);
      check("contend_ready", 64'(bus_a.req_ready_o), 64'd1 << exp_c);
      q_a.push_back('{client: 8'(exp_c),
                      data: (exp_c == 1) ? 32'h12345678 : 32'hDEADBEEF, err: 1'b0});
      tick();
    end
    clear_reqs();
    repeat (4) tick();

    // Reset asserted the cycle after a write is accepted
    drive_a(0, 1'b1, 1, 32'h55555555);
    @(negedge clk);
    check("rst_wr_ready", 64'(bus_a.req_ready_o), 64'b01);
    tick();
    clear_reqs();
    rst = 1'b1;
    bus_a.req_valid_i = 2'b01;
    @(negedge clk);
    check("rst_ready_forced", 64'(bus_a.req_ready_o), 64'd0);
    check("rst_write_suppressed", 64'(bus_a.rf_write_select_o), 64'd0);
    tick();
    rst = 1'b0;
    clear_reqs();
    @(negedge clk);
    check("rst_after_resp_valid", 64'(bus_a.resp_valid_o), 64'd0);
    check("rst_after_resp_data", 64'(bus_a.resp_data_o), 64'd0);
    check("rst_after_resp_error", 64'(bus_a.resp_error_o), 64'd0);
    check("rst_after_select", 64'(bus_a.rf_register_select_o), 64'd0);
    check("rst_after_write_sel", 64'(bus_a.rf_write_select_o), 64'd0);
    check("rst_after_rf_data", 64'(bus_a.rf_data_o), 64'd0);
    check("rst_reg1_unchanged", 64'(mem_a[1]), 64'h11111111);
    repeat (3) tick();

    // Out-of-range write on the 3-register instance, then an in-range read
    drive_b(0, 1'b1, 3, 32'hAAAA5555);
    @(negedge clk);
    check("oor_ready", 64'(bus_b.req_ready_o), 64'b01);
    q_b.push_back('{client: 8'd0, data: 32'h0, err: 1'b1});
    tick();
    clear_reqs();
    drive_b(1, 1'b0, 2, 32'h0);
    @(negedge clk);
    check("oor_select", 64'(bus_b.rf_register_select_o), 64'd0);
    check("oor_write_sel", 64'(bus_b.rf_write_select_o), 64'd0);
    q_b.push_back('{client: 8'd1, data: 32'hC0DE0000, err: 1'b0});
    tick();
    clear_reqs();
    @(negedge clk);
    check("b_read_select", 64'(bus_b.rf_register_select_o), 64'b100);
    repeat (4) tick();
    check("oor_no_write", 64'(b_write_seen), 64'd0);
    check("queue_a_drained", 64'(q_a.size()), 64'd0);
    check("queue_b_drained", 64'(q_b.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
